// File: rtl/tt_um_serial_addsub.sv
// tt_um_serial_addsub: bit-serial adder/subtractor with a nibble-wide load and read port.
// Operands are loaded four bits at a time. One result bit is computed per enabled clock,
// LSB first. The result is then read back four bits at a time.
// Optional feature macro: SUB_EN. When it is defined, uio_in[3] selects subtraction.
// When it is undefined, the block only adds.
module tt_um_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             loadIn;
    logic             startIn;
    logic             rdIn;
    logic             subIn;
    logic             unusedPins;

    logic             bEff;
    logic             sumBit;
    logic             carryNext;
    logic [WIDTH+3:0] aShift;
    logic [WIDTH+3:0] bShift;

    assign loadIn  = uio_in[0];
    assign startIn = uio_in[1];
    assign rdIn    = uio_in[2];

`ifdef SUB_EN
    assign subIn      = uio_in[3];
    assign unusedPins = ^uio_in[7:4];
`else
    assign subIn      = 1'b0;
    assign unusedPins = ^uio_in[7:3];
`endif

    // Full-adder slice on the current LSBs. The B bit is inverted for subtraction.
    always_comb begin
        bEff      = b_q[0] ^ sub_q;
        sumBit    = a_q[0] ^ bEff ^ carry_q;
        carryNext = (a_q[0] & bEff) | (a_q[0] & carry_q) | (bEff & carry_q);
    end

    // Nibble loads enter at the MSB end, so the first nibble loaded ends up least significant.
    always_comb begin
        aShift = {ui_in[3:0], a_q} >> 4;
        bShift = {ui_in[7:4], b_q} >> 4;
    end

    // Next-state logic. Nothing changes while ena is low. Start takes priority over load,
    // and load takes priority over rd.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (ena) begin
            case (state_q)
                IDLE, DONE: begin
                    if (startIn) begin
                        state_d = CALC;
                        cnt_d   = '0;
                        s_d     = '0;
                        cout_d  = 1'b0;
                        ovf_d   = 1'b0;
                        sub_d   = subIn;
                        carry_d = subIn;
                    end else if (loadIn) begin
                        a_d     = aShift[WIDTH-1:0];
                        b_d     = bShift[WIDTH-1:0];
                        state_d = IDLE;
                    end else if (rdIn && (state_q == DONE)) begin
                        s_d = s_q >> 4;
                    end
                end
                CALC: begin
                    s_d     = {sumBit, s_q[WIDTH-1:1]};
                    a_d     = {a_q[0], a_q[WIDTH-1:1]};
                    b_d     = {b_q[0], b_q[WIDTH-1:1]};
                    carry_d = carryNext;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                        cout_d  = carryNext ^ sub_q;
                        ovf_d   = carry_q ^ carryNext;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers. Reset clears all of them, which aborts any operation in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign uo_out  = {ovf_q, (state_q == DONE), (state_q == CALC), cout_q, s_q[3:0]};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_serial_addsub.sv
// tb_tt_um_serial_addsub: directed-vector bench for tt_um_serial_addsub with WIDTH=16.
module tb_tt_um_serial_addsub;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int vectors = 0;
   int miscompares = 0;

   tt_um_serial_addsub #(.WIDTH(16)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   // 10 ns clock period.
   always #5 clk = ~clk;

   // Count one comparison and report it if the observed value differs from the expected one.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, pass one rising edge, then drop the control pulses.
   task automatic applyStimulus(input logic [7:0] ui, input logic [7:0] uio);
      ui_in  = ui;
      uio_in = uio;
      @(posedge clk);
      #1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
   endtask

   // Load the 16-bit operands A and B, least significant nibble first.
   task automatic loadOperands(input logic [15:0] a, input logic [15:0] b);
      for (int i = 0; i < 4; i++) applyStimulus({b[4*i +: 4], a[4*i +: 4]}, 8'h01);
   endtask

   // Wait for done, with a bound of 100 edges.
   task automatic waitDone(output int edges);
      edges = 0;
      while (uo_out[6] !== 1'b1 && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   // Read all four result nibbles using three rd pulses.
   task automatic readResult(output logic [15:0] s);
      s = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         s[4*i +: 4] = uo_out[3:0];
         if (i < 3) applyStimulus(8'h00, 8'h04);
      end
   endtask

   // Finish a started calculation and check its latency, the flags {ovf,done,busy,cout} and the sum.
   task automatic finishCalc(input string tag, input int edgesSoFar, input int expEdges,
                             input logic [15:0] expS, input logic [3:0] expFlags);
      int n;
      logic [15:0] s;
      waitDone(n);
      checkOutput({tag, " latency"}, n + edgesSoFar, expEdges);
      checkOutput({tag, " flags"}, uo_out[7:4], expFlags);
      readResult(s);
      checkOutput({tag, " sum"}, s, expS);
   endtask

   initial begin
      int n;
      $display("[TB] start");
      // Reset state.
      @(posedge clk);
      #1;
      checkOutput("reset uo_out", uo_out, 8'h00);
      checkOutput("reset uio_out", uio_out, 8'h00);
      checkOutput("reset uio_oe", uio_oe, 8'h00);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic add, with a step-by-step nibble readout.
      loadOperands(16'h1234, 16'h0FCD);
      applyStimulus(8'h00, 8'h02);
      checkOutput("busy after start", uo_out[5], 1'b1);
      waitDone(n);
      checkOutput("add1 latency", n, 16);
      checkOutput("add1 flags", uo_out[7:4], 4'b0100);
      checkOutput("rd nibble0", uo_out[3:0], 4'h1);
      applyStimulus(8'h00, 8'h04);
      checkOutput("rd nibble1", uo_out[3:0], 4'h0);
      applyStimulus(8'h00, 8'h04);
      checkOutput("rd nibble2", uo_out[3:0], 4'h2);
      applyStimulus(8'h00, 8'h04);
      checkOutput("rd nibble3", uo_out[3:0], 4'h2);
      applyStimulus(8'h00, 8'h04);
      checkOutput("rd past end", uo_out[3:0], 4'h0);
      applyStimulus(8'h00, 8'h04);
      checkOutput("rd past end 2", uo_out[3:0], 4'h0);

      // Restart from DONE without reloading. The operands must have been restored.
      applyStimulus(8'h00, 8'h02);
      finishCalc("recompute", 0, 16, 16'h2201, 4'b0100);

      // Carry out of the top bit, with no signed overflow.
      loadOperands(16'hFFFF, 16'h0001);
      applyStimulus(8'h00, 8'h02);
      finishCalc("ffff+1", 0, 16, 16'h0000, 4'b0101);

      // Signed overflow, with no carry out.
      loadOperands(16'h7FFF, 16'h0001);
      applyStimulus(8'h00, 8'h02);
      finishCalc("7fff+1", 0, 16, 16'h8000, 4'b1100);

      // Start with the sub bit set.
      loadOperands(16'h0005, 16'h0007);
      applyStimulus(8'h00, 8'h0A);
`ifdef SUB_EN
      finishCalc("5-7", 0, 16, 16'hFFFE, 4'b0101);
`else
      finishCalc("5 sub ignored", 0, 16, 16'h000C, 4'b0100);
`endif

      // Load and start together in IDLE: start wins, and the operands stay as loaded.
      loadOperands(16'h1234, 16'h0FCD);
      applyStimulus(8'hFF, 8'h03);
      finishCalc("load+start", 1, 17, 16'h2201, 4'b0100);

      // Pulses on load, rd and start while busy must be ignored.
      applyStimulus(8'h00, 8'h02);
      applyStimulus(8'hFF, 8'h01);
      applyStimulus(8'h00, 8'h04);
      applyStimulus(8'h00, 8'h02);
      applyStimulus(8'h77, 8'h07);
      finishCalc("busy noise", 4, 16, 16'h2201, 4'b0100);
      applyStimulus(8'h00, 8'h02);
      finishCalc("after noise", 0, 16, 16'h2201, 4'b0100);

      // Holding ena low for 5 cycles mid-calculation delays done by exactly 5 cycles.
      applyStimulus(8'h00, 8'h02);
      for (int i = 0; i < 6; i++) applyStimulus(8'h00, 8'h00);
      ena = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(8'h5A, 8'h07);
      checkOutput("ena hold busy", uo_out[5], 1'b1);
      ena = 1'b1;
      finishCalc("ena pause", 11, 21, 16'h2201, 4'b0100);

      // Reset asserted mid-calculation clears uo_out at once and leaves the block IDLE.
      applyStimulus(8'h00, 8'h02);
      for (int i = 0; i < 8; i++) applyStimulus(8'h00, 8'h00);
      checkOutput("mid busy", uo_out[5], 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset uo_out", uo_out, 8'h00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("idle after reset", uo_out, 8'h00);
      applyStimulus(8'h00, 8'h02);
      finishCalc("cleared operands", 0, 16, 16'h0000, 4'b0100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
